regbank_router: RTL and testbench
=================================

Name: regbank_router

Overview:
- Parametrised successor to the fixed 8-register SPI register wrapper.
- Sits between spi_slave and the register/peripheral blocks.
- Decodes the SPI address phase into NUM_REGS one-hot write/read strobes and registers the read-data mux.
- Supports multi-byte bursts with optional address auto-increment, and flags accesses to unmapped addresses.

Parameters:
- NUM_REGS, 16: number of mapped registers; valid addresses are 0..NUM_REGS-1. Range 2..2**ADDR_W.
- ADDR_W, 7: width of reg_addr.
- DATA_W, 8: register/byte width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- addr_dv  in  1  address phase valid from spi_slave; high for the whole transaction.
- reg_addr  in  ADDR_W  register address, sampled at the addr_dv rising edge.
- rw_out  in  1  1 = read (target to host), 0 = write; sampled with reg_addr.
- rxdv  in  1  received byte valid; may be high for multiple cycles.
- rx_d  in  DATA_W  received byte.
- tx_ack  in  1  one-cycle pulse from spi_slave when the current tx_d byte has been shifted out.
- tx_d  out  DATA_W  read data to spi_slave.
- tx_en  out  1  tx_d valid.
- wr_stb  out  NUM_REGS  one-hot, one-cycle write strobe.
- wr_data  out  DATA_W  write data; valid while any wr_stb bit is high.
- rd_stb  out  NUM_REGS  one-hot, one-cycle pulse when a register's value is loaded into tx_d (used for FIFO pop side effects).
- rd_data  in  NUM_REGS*DATA_W  flattened register read values; register i occupies bits [i*DATA_W +: DATA_W].
- addr_err  out  1  one-cycle pulse on any access to an address >= NUM_REGS.

Behaviour:
- Reset: on reset sampled high at a clk edge, all outputs go to 0 (tx_d, tx_en, wr_stb, wr_data, rd_stb, addr_err), state = IDLE, cur_addr = 0, rxdv_q = 0. Reset mid-transaction aborts it; no strobe is issued at or after that edge.
- rxdv_q: registers rxdv every cycle. Byte event = rxdv & ~rxdv_q.
- States: IDLE, ADDR, WR, RD_LOAD, RD_HOLD.
- IDLE: when addr_dv is sampled high, capture cur_addr <= reg_addr and cur_rw <= rw_out, then go to ADDR.
- ADDR: go to WR if cur_rw = 0, otherwise RD_LOAD.
- WR, on a byte event:
  - If cur_addr < NUM_REGS: at the next edge, wr_stb[cur_addr] = 1 and wr_data = rx_d, held for one cycle.
  - Otherwise: wr_stb stays 0 and addr_err pulses.
  - In both cases cur_addr advances (see increment rule).
  - Write latency: 1 cycle from the sampled byte event.
- WR ignores tx_ack.
- RD_LOAD, on its edge:
  - tx_d <= rd_data slice at cur_addr, or all-ones if unmapped.
  - tx_en <= 1.
  - rd_stb[cur_addr] <= 1 for one cycle if mapped; addr_err pulses if unmapped.
  - Next state RD_HOLD.
  - tx_en therefore rises 2 edges after addr_dv is first sampled high.
- RD_HOLD:
  - tx_d is held stable.
  - tx_ack: advance cur_addr, go to RD_LOAD. The next byte is valid 2 edges after tx_ack. tx_en stays high throughout.
  - Byte events are ignored.
- Increment rule: cur_addr <= (cur_addr == NUM_REGS-1) ? 0 : cur_addr+1. Unmapped addresses also increment modulo 2**ADDR_W.
- addr_dv low in any non-IDLE state: go to IDLE next edge with tx_en = 0 and tx_d = 0. This takes priority over a simultaneous byte event or tx_ack; that byte is dropped and no strobe is issued.
- addr_dv held high with a changed reg_addr: ignored. A new address requires addr_dv to return low.
- wr_stb and rd_stb are never high in the same cycle. At most one bit of each is high.

Optional Feature:
- Macro: REGBANK_ROUTER_AUTOINC_EN.
- Defined: cur_addr advances per the increment rule after every byte.
- Undefined: cur_addr stays fixed for the whole transaction. Bursts repeatedly access one register, e.g. streaming a packet FIFO. Repeated rd_stb pulses pop successive entries.

Test Plan:
- Reset in WR state:
  - Stimulus: reset high during WR, one cycle after a byte event.
  - Required: wr_stb = 0 at every edge from the reset edge on; state IDLE; tx_en = 0.
- Single write:
  - Stimulus: addr_dv = 1, reg_addr = 7'h03, rw_out = 0, then rxdv high 3 cycles with rx_d = 8'hA5.
  - Required: exactly one cycle with wr_stb = 16'h0008 and wr_data = 8'hA5, one cycle after the rxdv rise; addr_err never pulses.
- Burst read with AUTOINC:
  - Stimulus: rd_data reg14 = 8'h11, reg15 = 8'h22, reg0 = 8'h33; addr_dv = 1, reg_addr = 7'h0E, rw_out = 1; three tx_ack pulses.
  - Required: tx_d sequence 8'h11, 8'h22, 8'h33; rd_stb pulses bits 14, 15, 0 (wrap); tx_en high until addr_dv falls.
- Burst read without AUTOINC:
  - Stimulus: same as the AUTOINC burst read, macro undefined.
  - Required: rd_stb bit 14 pulses 3 times; tx_d = 8'h11 each time.
- Unmapped write and read:
  - Stimulus: reg_addr = 7'h20, write of 8'h5A, then a separate read transaction.
  - Required: write gives no wr_stb and one addr_err pulse; read gives tx_d = 8'hFF, tx_en = 1, rd_stb = 0, one addr_err pulse.
- Abort on addr_dv fall:
  - Stimulus: addr_dv falls in the same cycle as a byte event during WR.
  - Required: no wr_stb; state IDLE next edge; tx_d = 0, tx_en = 0.

Source files
------------

// File: rtl/regbank_router.sv
// regbank_router
// Routes SPI transactions from spi_slave onto a bank of NUM_REGS registers.
// The address phase selects a start register and direction; write bursts turn
// each received byte into a one-hot write strobe, read bursts load the selected
// register into tx_d and pulse a one-hot read strobe per byte shifted out.
// Accesses to addresses >= NUM_REGS pulse addr_err instead of a strobe.
//
// Optional feature macro: REGBANK_ROUTER_AUTOINC_EN
//   defined   : cur_addr advances after every byte (wrapping NUM_REGS-1 -> 0)
//   undefined : cur_addr stays fixed for the whole transaction
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   addr_dv            transaction active (address phase valid)
//   reg_addr, rw_out   start address and direction (1 = read), sampled in IDLE
//   rxdv, rx_d         received byte valid / data (level, edge-detected here)
//   tx_ack             current tx_d byte has been shifted out
//   tx_d, tx_en        read data to spi_slave and its valid
//   wr_stb, wr_data    one-hot write strobe and write data
//   rd_stb             one-hot pulse when a register is loaded into tx_d
//   rd_data            flattened register read values
//   addr_err           pulse on any access to an unmapped address
module regbank_router #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         addr_dv,
    input  logic [ADDR_W-1:0]            reg_addr,
    input  logic                         rw_out,
    input  logic                         rxdv,
    input  logic [DATA_W-1:0]            rx_d,
    input  logic                         tx_ack,
    output logic [DATA_W-1:0]            tx_d,
    output logic                         tx_en,
    output logic [NUM_REGS-1:0]          wr_stb,
    output logic [DATA_W-1:0]            wr_data,
    output logic [NUM_REGS-1:0]          rd_stb,
    input  logic [NUM_REGS*DATA_W-1:0]   rd_data,
    output logic                         addr_err
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WR,
        RD_LOAD,
        RD_HOLD
    } state_t;

    state_t                state, state_n;
    logic [ADDR_W-1:0]     cur_addr, cur_addr_n, addr_inc;
    logic                  cur_rw, cur_rw_n;
    logic                  rxdv_q;
    logic                  byte_evt;
    logic                  addr_mapped;
    logic [NUM_REGS-1:0]   addr_onehot;
    logic [DATA_W-1:0]     rd_sel;
    logic [DATA_W-1:0]     tx_d_n, wr_data_n;
    logic                  tx_en_n, addr_err_n;
    logic [NUM_REGS-1:0]   wr_stb_n, rd_stb_n;

    assign byte_evt = rxdv & ~rxdv_q;

    // Address decode: a constant-index loop gives the one-hot strobe pattern and
    // the read mux together; an unmapped address matches nothing, so the mux
    // falls through to all-ones and the one-hot vector stays zero.
    always_comb begin
        addr_onehot = '0;
        rd_sel      = '1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cur_addr == ADDR_W'(i)) begin
                addr_onehot[i] = 1'b1;
                rd_sel         = rd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign addr_mapped = |addr_onehot;

`ifdef REGBANK_ROUTER_AUTOINC_EN
    // Mapped addresses wrap at the top of the bank; unmapped ones simply roll
    // over at 2**ADDR_W through the natural adder width.
    assign addr_inc = (cur_addr == ADDR_W'(NUM_REGS - 1)) ? '0 : cur_addr + ADDR_W'(1);
`else
    assign addr_inc = cur_addr;
`endif

    // Next-state and output logic. Dropping addr_dv outside IDLE wins over any
    // byte event or tx_ack in the same cycle, so an aborted byte never strobes.
    always_comb begin
        state_n    = state;
        cur_addr_n = cur_addr;
        cur_rw_n   = cur_rw;
        tx_d_n     = tx_d;
        tx_en_n    = tx_en;
        wr_data_n  = wr_data;
        wr_stb_n   = '0;
        rd_stb_n   = '0;
        addr_err_n = 1'b0;

        if (state != IDLE && !addr_dv) begin
            state_n = IDLE;
            tx_en_n = 1'b0;
            tx_d_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_en_n = 1'b0;
                    tx_d_n  = '0;
                    if (addr_dv) begin
                        cur_addr_n = reg_addr;
                        cur_rw_n   = rw_out;
                        state_n    = ADDR;
                    end
                end
                ADDR: begin
                    state_n = cur_rw ? RD_LOAD : WR;
                end
                WR: begin
                    if (byte_evt) begin
                        if (addr_mapped) begin
                            wr_stb_n  = addr_onehot;
                            wr_data_n = rx_d;
                        end else begin
                            addr_err_n = 1'b1;
                        end
                        cur_addr_n = addr_inc;
                    end
                end
                RD_LOAD: begin
                    tx_d_n     = rd_sel;
                    tx_en_n    = 1'b1;
                    rd_stb_n   = addr_onehot;
                    addr_err_n = ~addr_mapped;
                    state_n    = RD_HOLD;
                end
                RD_HOLD: begin
                    if (tx_ack) begin
                        cur_addr_n = addr_inc;
                        state_n    = RD_LOAD;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // All state and registered outputs; reset clears everything, which also
    // aborts any transaction in flight without issuing a strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cur_addr <= '0;
            cur_rw   <= 1'b0;
            rxdv_q   <= 1'b0;
            tx_d     <= '0;
            tx_en    <= 1'b0;
            wr_stb   <= '0;
            wr_data  <= '0;
            rd_stb   <= '0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_n;
            cur_addr <= cur_addr_n;
            cur_rw   <= cur_rw_n;
            rxdv_q   <= rxdv;
            tx_d     <= tx_d_n;
            tx_en    <= tx_en_n;
            wr_stb   <= wr_stb_n;
            wr_data  <= wr_data_n;
            rd_stb   <= rd_stb_n;
            addr_err <= addr_err_n;
        end
    end

endmodule

// File: tb/tb_regbank_router.sv
// tb_regbank_router
// Self-checking bench for regbank_router. Drives directed and randomized
// write/read transactions on the negative clock edge and compares every
// registered output after each rising edge against a transaction-level model
// (address sequence, one-hot strobe, expected read byte) held in this file.
// Honors REGBANK_ROUTER_AUTOINC_EN the same way the design does.
module tb_regbank_router;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        addr_dv;
    logic [ADDR_W-1:0]           reg_addr;
    logic                        rw_out;
    logic                        rxdv;
    logic [DATA_W-1:0]           rx_d;
    logic                        tx_ack;
    logic [DATA_W-1:0]           tx_d;
    logic                        tx_en;
    logic [NUM_REGS-1:0]         wr_stb;
    logic [DATA_W-1:0]           wr_data;
    logic [NUM_REGS-1:0]         rd_stb;
    logic [NUM_REGS*DATA_W-1:0]  rd_data;
    logic                        addr_err;

    logic [DATA_W-1:0]           regs [NUM_REGS];

    int vectors     = 0;
    int miscompares = 0;

    regbank_router #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr_dv  (addr_dv),
        .reg_addr (reg_addr),
        .rw_out   (rw_out),
        .rxdv     (rxdv),
        .rx_d     (rx_d),
        .tx_ack   (tx_ack),
        .tx_d     (tx_d),
        .tx_en    (tx_en),
        .wr_stb   (wr_stb),
        .wr_data  (wr_data),
        .rd_stb   (rd_stb),
        .rd_data  (rd_data),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_rd
        assign rd_data[g*DATA_W +: DATA_W] = regs[g];
    end

    // Reference model: which addresses exist, what strobe and byte they give,
    // and where the address goes after each byte.
    function automatic logic mapped(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(NUM_REGS);
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] one;
        one = 1;
        return mapped(a) ? (one << a[3:0]) : '0;
    endfunction

    function automatic logic [DATA_W-1:0] rdval(input logic [ADDR_W-1:0] a);
        return mapped(a) ? regs[a[3:0]] : 8'hFF;
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef REGBANK_ROUTER_AUTOINC_EN
        if (int'(a) == NUM_REGS - 1) return '0;
        return a + ADDR_W'(1);
`else
        return a;
`endif
    endfunction

    // Drive one cycle of inputs at the falling edge, then step to the next
    // falling edge so the following check sees the rising-edge result.
    task automatic applyStimulus(input logic dv, input logic [ADDR_W-1:0] ra,
                                 input logic rw, input logic rv,
                                 input logic [DATA_W-1:0] rd, input logic ack);
        addr_dv  = dv;
        reg_addr = ra;
        rw_out   = rw;
        rxdv     = rv;
        rx_d     = rd;
        tx_ack   = ack;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [NUM_REGS-1:0] ew,
                               input logic [DATA_W-1:0] ewd, input logic [NUM_REGS-1:0] er,
                               input logic ee, input logic eten, input logic [DATA_W-1:0] etd);
        vectors++;
        assert (wr_stb === ew) else begin
            miscompares++;
            $error("[TB] FAIL %s wr_stb observed %h expected %h", tag, wr_stb, ew);
        end
        if (ew != '0) begin
            assert (wr_data === ewd) else begin
                miscompares++;
                $error("[TB] FAIL %s wr_data observed %h expected %h", tag, wr_data, ewd);
            end
        end
        assert (rd_stb === er) else begin
            miscompares++;
            $error("[TB] FAIL %s rd_stb observed %h expected %h", tag, rd_stb, er);
        end
        assert (addr_err === ee) else begin
            miscompares++;
            $error("[TB] FAIL %s addr_err observed %b expected %b", tag, addr_err, ee);
        end
        assert (tx_en === eten) else begin
            miscompares++;
            $error("[TB] FAIL %s tx_en observed %b expected %b", tag, tx_en, eten);
        end
        assert (tx_d === etd) else begin
            miscompares++;
            $error("[TB] FAIL %s tx_d observed %h expected %h", tag, tx_d, etd);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput(tag, '0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    // Write burst: hold < 0 picks a random number of extra rxdv-high cycles.
    task automatic writeTxn(input logic [ADDR_W-1:0] addr, input int nbytes,
                            input bit use_fixed, input logic [DATA_W-1:0] fixed_val,
                            input int hold);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] b;
        int h;
        a = addr;
        applyStimulus(1'b1, addr, 1'b0, 1'b0, '0, 1'b0);
        checkIdle("wr_addr_phase");
        applyStimulus(1'b1, ADDR_W'($urandom), 1'($urandom), 1'b0, '0, 1'b0);
        checkIdle("wr_enter");
        for (int k = 0; k < nbytes; k++) begin
            b = use_fixed ? fixed_val : DATA_W'($urandom);
            applyStimulus(1'b1, ADDR_W'($urandom), 1'($urandom), 1'b1, b, 1'($urandom));
            checkOutput("wr_byte", onehot(a), b, '0, ~mapped(a), 1'b0, '0);
            h = (hold < 0) ? int'($urandom_range(0, 2)) : hold;
            for (int j = 0; j < h; j++) begin
                applyStimulus(1'b1, reg_addr, rw_out, 1'b1, DATA_W'($urandom), 1'b0);
                checkIdle("wr_hold");
            end
            applyStimulus(1'b1, reg_addr, rw_out, 1'b0, DATA_W'($urandom), 1'b0);
            checkIdle("wr_gap");
            a = next_addr(a);
        end
        applyStimulus(1'b0, reg_addr, rw_out, 1'b0, '0, 1'b0);
        checkIdle("wr_end");
    endtask

    // Read burst: one tx_ack per extra byte, with random hold time and
    // ignored rxdv activity while a byte is waiting to be shifted out.
    task automatic readTxn(input logic [ADDR_W-1:0] addr, input int nbytes, input bit keep_regs);
        logic [ADDR_W-1:0] a;
        int h;
        if (!keep_regs) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'($urandom);
        end
        a = addr;
        applyStimulus(1'b1, addr, 1'b1, 1'b0, '0, 1'b0);
        checkIdle("rd_addr_phase");
        applyStimulus(1'b1, ADDR_W'($urandom), 1'($urandom), 1'b0, '0, 1'b0);
        checkIdle("rd_enter");
        applyStimulus(1'b1, reg_addr, rw_out, 1'($urandom), DATA_W'($urandom), 1'b0);
        checkOutput("rd_first", '0, '0, onehot(a), ~mapped(a), 1'b1, rdval(a));
        for (int k = 1; k < nbytes; k++) begin
            h = int'($urandom_range(0, 2));
            for (int j = 0; j < h; j++) begin
                applyStimulus(1'b1, reg_addr, rw_out, 1'($urandom), DATA_W'($urandom), 1'b0);
                checkOutput("rd_hold", '0, '0, '0, 1'b0, 1'b1, rdval(a));
            end
            applyStimulus(1'b1, reg_addr, rw_out, 1'b0, '0, 1'b1);
            checkOutput("rd_ack", '0, '0, '0, 1'b0, 1'b1, rdval(a));
            a = next_addr(a);
            applyStimulus(1'b1, reg_addr, rw_out, 1'b0, '0, 1'b0);
            checkOutput("rd_next", '0, '0, onehot(a), ~mapped(a), 1'b1, rdval(a));
        end
        applyStimulus(1'b1, reg_addr, rw_out, 1'b0, '0, 1'b0);
        checkOutput("rd_last_hold", '0, '0, '0, 1'b0, 1'b1, rdval(a));
        applyStimulus(1'b0, reg_addr, rw_out, 1'b0, '0, 1'b0);
        checkIdle("rd_end");
        applyStimulus(1'b0, reg_addr, rw_out, 1'b0, '0, 1'b0);
        checkIdle("rd_idle");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] ra;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'(i * 17);

        // Reset state.
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 7'h03, 1'b0, 1'b1, 8'hFF, 1'b1);
        checkIdle("reset");
        reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        checkIdle("post_reset");

        // Reset one cycle after a byte event in WR.
        applyStimulus(1'b1, 7'h05, 1'b0, 1'b0, '0, 1'b0);
        checkIdle("rst_wr_addr");
        applyStimulus(1'b1, 7'h05, 1'b0, 1'b0, '0, 1'b0);
        checkIdle("rst_wr_enter");
        applyStimulus(1'b1, 7'h05, 1'b0, 1'b1, 8'h3C, 1'b0);
        checkOutput("rst_wr_byte", 16'h0020, 8'h3C, '0, 1'b0, 1'b0, '0);
        reset = 1'b1;
        applyStimulus(1'b1, 7'h05, 1'b0, 1'b0, 8'h3C, 1'b0);
        checkIdle("rst_edge");
        applyStimulus(1'b1, 7'h05, 1'b0, 1'b1, 8'h3C, 1'b0);
        checkIdle("rst_hold");
        reset = 1'b0;
        applyStimulus(1'b0, 7'h05, 1'b0, 1'b0, '0, 1'b0);
        checkIdle("rst_release");
        applyStimulus(1'b0, 7'h05, 1'b0, 1'b0, '0, 1'b0);
        checkIdle("rst_idle");

        // Single write of A5 to register 3 with rxdv high for three cycles.
        writeTxn(7'h03, 1, 1'b1, 8'hA5, 2);

        // Burst read starting at 14 across the top of the bank.
        regs[14] = 8'h11;
        regs[15] = 8'h22;
        regs[0]  = 8'h33;
        readTxn(7'h0E, 3, 1'b1);

        // Unmapped write then unmapped read.
        writeTxn(7'h20, 1, 1'b1, 8'h5A, -1);
        readTxn(7'h20, 1, 1'b0);

        // Abort: addr_dv falls together with a byte event.
        applyStimulus(1'b1, 7'h02, 1'b0, 1'b0, '0, 1'b0);
        checkIdle("abort_addr");
        applyStimulus(1'b1, 7'h02, 1'b0, 1'b0, '0, 1'b0);
        checkIdle("abort_enter");
        applyStimulus(1'b0, 7'h02, 1'b0, 1'b1, 8'h77, 1'b0);
        checkIdle("abort_edge");
        applyStimulus(1'b0, 7'h02, 1'b0, 1'b0, '0, 1'b0);
        checkIdle("abort_idle");

        // Boundary addresses: last mapped, last possible, first unmapped.
        writeTxn(7'h0F, 2, 1'b0, '0, -1);
        writeTxn(7'h7F, 2, 1'b0, '0, -1);
        readTxn(7'h7F, 2, 1'b0);
        readTxn(7'h10, 2, 1'b0);

        // Randomized transactions, biased toward mapped addresses.
        for (int t = 0; t < 24; t++) begin
            ra = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, NUM_REGS - 1));
            if ($urandom_range(0, 1) == 1)
                readTxn(ra, int'($urandom_range(1, 4)), 1'b0);
            else
                writeTxn(ra, int'($urandom_range(1, 4)), 1'b0, '0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
